// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states
// and small op-decode helpers.
package muldiv_pkg;
    localparam int W_DEF = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_mul(input logic [1:0] op);
        return ~op[1];
    endfunction
endpackage

// File: rtl/muldiv_iter_core.sv
// Radix-2 datapath: magnitude operands, a shared 2W accumulator ({hi,lo} product or
// {remainder,quotient}), one shift-add / restoring-subtract step per cycle, sign fix-up.
module muldiv_iter_core
    import muldiv_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         i_load,
    input  logic         i_step,
    input  logic [1:0]   i_op,
    input  logic [W-1:0] i_srca,
    input  logic [W-1:0] i_srcb,
    output logic [W-1:0] o_hi,
    output logic [W-1:0] o_lo
);
    logic [2*W-1:0] r_acc;
    logic [W-1:0]   r_opnd;
    logic           r_mul;
    logic           r_neg_lo;
    logic           r_neg_hi;
    logic           r_div0;

    logic           w_sa;
    logic           w_sb;
    logic [W-1:0]   w_absa;
    logic [W-1:0]   w_absb;
    logic [W:0]     w_sum;
    logic [W:0]     w_rem_sh;
    logic [W:0]     w_diff;
    logic [2*W-1:0] w_prod;

    function automatic logic [W-1:0] neg_w(input logic [W-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    always_comb begin
        w_sa     = op_is_signed(i_op) & i_srca[W-1];
        w_sb     = op_is_signed(i_op) & i_srcb[W-1];
        w_absa   = neg_w(i_srca, w_sa);
        w_absb   = neg_w(i_srcb, w_sb);
        w_sum    = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
        w_rem_sh = r_acc[2*W-1:W-1];
        w_diff   = w_rem_sh - {1'b0, r_opnd};
        w_prod   = neg_2w(r_acc, r_neg_lo);
    end

    // Multiply keeps |a| as the addend and shifts |b| out of the low half;
    // divide keeps |b| as the divisor and shifts |a| into the remainder.
    always_ff @(posedge clk) begin
        if (i_load) begin
            r_mul    <= op_is_mul(i_op);
            r_opnd   <= op_is_mul(i_op) ? w_absa : w_absb;
            r_acc    <= {{W{1'b0}}, (op_is_mul(i_op) ? w_absb : w_absa)};
            r_neg_lo <= w_sa ^ w_sb;
            r_neg_hi <= op_is_mul(i_op) ? (w_sa ^ w_sb) : w_sa;
            r_div0   <= ~op_is_mul(i_op) & (i_srcb == '0);
        end else if (i_step) begin
            if (r_mul)
                r_acc <= {w_sum, r_acc[W-1:1]};
            else if (w_diff[W])
                r_acc <= {w_rem_sh[W-1:0], r_acc[W-2:0], 1'b0};
            else
                r_acc <= {w_diff[W-1:0], r_acc[W-2:0], 1'b1};
        end
    end

    // A zero divisor leaves |a| in the remainder, so the dividend-sign fix restores srca.
    always_comb begin
        if (r_mul) begin
            o_hi = w_prod[2*W-1:W];
            o_lo = w_prod[W-1:0];
        end else begin
            o_hi = neg_w(r_acc[2*W-1:W], r_neg_hi);
            o_lo = r_div0 ? '1 : neg_w(r_acc[W-1:0], r_neg_lo);
        end
    end
endmodule

// File: rtl/muldiv_sequencer.sv
// Multiply/divide controller owning HI/LO: IDLE/RUN/FIX sequencing, iteration counter,
// MTHI/MTLO writes and the decode-stage stall request.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_E,
    input  logic [1:0]   op_E,
    input  logic [W-1:0] srca_E,
    input  logic [W-1:0] srcb_E,
    input  logic         hilo_use_D,
    input  logic         write_hi_W,
    input  logic         write_lo_W,
    input  logic [W-1:0] wdata_W,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         busy,
    output logic         done,
    output logic         stall_req
);
    localparam int CW = $clog2(W);

    state_e         r_state;
    state_e         w_next;
    logic [CW-1:0]  r_count;
    logic           w_load;
    logic           w_step;
    logic [W-1:0]   w_fix_hi;
    logic [W-1:0]   w_fix_lo;

    muldiv_iter_core #(.W(W)) u_core (
        .clk    (clk),
        .i_load (w_load),
        .i_step (w_step),
        .i_op   (op_E),
        .i_srca (srca_E),
        .i_srcb (srcb_E),
        .o_hi   (w_fix_hi),
        .o_lo   (w_fix_lo)
    );

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_step = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_E) begin
                    w_next = RUN;
                    w_load = 1'b1;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (r_count == '0)
                    w_next = FIX;
            end
            FIX:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign busy      = (r_state != IDLE);
    assign done      = (r_state == FIX);
    assign stall_req = hilo_use_D & (busy | start_E);

    // The FIX write takes priority over any MTHI/MTLO retiring on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            r_state <= w_next;
            if (w_load)
                r_count <= CW'(W - 1);
            else if (w_step && (r_count != '0))
                r_count <= r_count - CW'(1);
            if (r_state == FIX) begin
                hi <= w_fix_hi;
                lo <= w_fix_lo;
            end else begin
                if (write_hi_W) hi <= wdata_W;
                if (write_lo_W) lo <= wdata_W;
            end
        end
    end
endmodule
